// File: rtl/abz_gen.sv
// Quadrature ABZ encoder emulator: steps a position counter toward a target one
// count at a time and drives registered A/B/Z with a minimum edge spacing.
module abz_gen #(
    parameter int BIT_LENGTH = 12,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  ARSTN,
    input  logic                  EN_IN,
    input  logic                  LOAD_IN,
    input  logic [BIT_LENGTH-1:0] INIT_COUNT,
    input  logic [BIT_LENGTH-1:0] TARGET_IN,
    input  logic [DIV_WIDTH-1:0]  STEP_DIV,
    input  logic [BIT_LENGTH-1:0] Z_COUNT,
    output logic                  A_OUT,
    output logic                  B_OUT,
    output logic                  Z_OUT,
    output logic [BIT_LENGTH-1:0] CUR_POS,
    output logic                  DIR_OUT,
    output logic                  BUSY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [BIT_LENGTH-1:0] HALF_TURN   = {1'b1, {(BIT_LENGTH-1){1'b0}}};
    localparam logic [BIT_LENGTH-1:0] POS_ONE     = BIT_LENGTH'(1);
    localparam logic [DIV_WIDTH-1:0]  MIN_SPACING = DIV_WIDTH'(2);
    localparam logic [DIV_WIDTH-1:0]  DIV_ONE     = DIV_WIDTH'(1);

    state_t                state_reg, state_next;
    logic [BIT_LENGTH-1:0] pos_reg, pos_next;
    logic [BIT_LENGTH-1:0] diff;
    logic [DIV_WIDTH-1:0]  timer_reg, timer_next;
    logic [DIV_WIDTH-1:0]  reload;
    logic                  dir_reg, dir_next;
    logic                  a_reg, b_reg, z_reg;
    logic                  move_req;
    logic                  go_up;

    always_comb begin
        diff     = TARGET_IN - pos_reg;
        move_req = EN_IN && (diff != '0);
        // Exactly half a turn is ambiguous; resolve it upward.
        go_up    = !diff[BIT_LENGTH-1] || (diff == HALF_TURN);
        reload   = ((STEP_DIV < MIN_SPACING) ? MIN_SPACING : STEP_DIV) - DIV_ONE;

        state_next = state_reg;
        pos_next   = pos_reg;
        dir_next   = dir_reg;
        timer_next = timer_reg;

        if (LOAD_IN) begin
            pos_next   = INIT_COUNT;
            timer_next = reload;
            state_next = WAIT;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (move_req) state_next = STEP;
                end
                STEP: begin
                    if (diff != '0) begin
                        pos_next   = go_up ? (pos_reg + POS_ONE) : (pos_reg - POS_ONE);
                        dir_next   = go_up;
                        timer_next = reload;
                        state_next = WAIT;
                    end else begin
                        state_next = IDLE;
                    end
                end
                WAIT: begin
                    // The STEP cycle itself is the last clock of the spacing,
                    // so leave WAIT as the timer reaches zero.
                    timer_next = timer_reg - DIV_ONE;
                    if (timer_reg <= DIV_ONE) begin
                        state_next = move_req ? STEP : IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge ARSTN) begin
        if (!ARSTN) begin
            state_reg <= IDLE;
            pos_reg   <= '0;
            dir_reg   <= 1'b0;
            timer_reg <= '0;
            a_reg     <= 1'b0;
            b_reg     <= 1'b0;
            z_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            pos_reg   <= pos_next;
            dir_reg   <= dir_next;
            timer_reg <= timer_next;
            a_reg     <= pos_next[1] ^ pos_next[0];
            b_reg     <= pos_next[1];
            z_reg     <= (pos_next == Z_COUNT);
        end
    end

    assign A_OUT   = a_reg;
    assign B_OUT   = b_reg;
    assign Z_OUT   = z_reg;
    assign CUR_POS = pos_reg;
    assign DIR_OUT = dir_reg;
    assign BUSY    = (state_reg != IDLE);

endmodule

// File: tb/tb_abz_gen.sv
// Scoreboard bench for abz_gen: stimulus queues expected edges, a monitor pops
// and compares them whenever A/B/position change, plus a loopback decoder.
module tb_abz_gen;

    logic        CLK;
    logic        ARSTN;
    logic        EN_IN;
    logic        LOAD_IN;
    logic [11:0] INIT_COUNT;
    logic [11:0] TARGET_IN;
    logic [15:0] STEP_DIV;
    logic [11:0] Z_COUNT;
    logic        A_OUT;
    logic        B_OUT;
    logic        Z_OUT;
    logic [11:0] CUR_POS;
    logic        DIR_OUT;
    logic        BUSY;

    abz_gen #(.BIT_LENGTH(12), .DIV_WIDTH(16)) dut (
        .CLK(CLK), .ARSTN(ARSTN), .EN_IN(EN_IN), .LOAD_IN(LOAD_IN),
        .INIT_COUNT(INIT_COUNT), .TARGET_IN(TARGET_IN), .STEP_DIV(STEP_DIV),
        .Z_COUNT(Z_COUNT), .A_OUT(A_OUT), .B_OUT(B_OUT), .Z_OUT(Z_OUT),
        .CUR_POS(CUR_POS), .DIR_OUT(DIR_OUT), .BUSY(BUSY)
    );

    typedef struct {
        logic [11:0] pos;
        logic [1:0]  ab;
        logic        z;
        logic        dir;
        logic        load;
        int          gap;
    } rec_t;

    rec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic exp_dir = 1'b0;
    logic [11:0] det_cnt;
    logic [1:0]  det_ab;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [1:0] phase(input logic [11:0] p);
        logic [1:0] r;
        case (p[1:0])
            2'd0:    r = 2'b00;
            2'd1:    r = 2'b10;
            2'd2:    r = 2'b11;
            default: r = 2'b01;
        endcase
        return r;
    endfunction

    function automatic int ab_index(input logic [1:0] ab);
        int r;
        case (ab)
            2'b00:   r = 0;
            2'b10:   r = 1;
            2'b11:   r = 2;
            default: r = 3;
        endcase
        return r;
    endfunction

    task automatic push_step(input logic [11:0] p, input logic dir, input int gap, input logic load);
        rec_t r;
        r.pos  = p;
        r.ab   = phase(p);
        r.z    = (p == Z_COUNT);
        r.dir  = dir;
        r.load = load;
        r.gap  = gap;
        exp_q.push_back(r);
        exp_dir = dir;
    endtask

    task automatic push_path(input logic [11:0] from, input logic [11:0] to,
                             input int first_gap, input int s);
        logic [11:0] cur, d;
        logic        up;
        int          g;
        cur = from;
        g   = first_gap;
        while (cur != to) begin
            d   = to - cur;
            up  = !d[11] || (d == 12'h800);
            cur = up ? cur + 12'd1 : cur - 12'd1;
            push_step(cur, up, g, 1'b0);
            g = s;
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        repeat (3) @(negedge CLK);
        while (BUSY && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check({name, "_idle_timeout"}, int'(BUSY), 0);
        check({name, "_queue_drained"}, exp_q.size(), 0);
    endtask

    task automatic wait_pos(input string name, input logic [11:0] p, input int budget);
        int n;
        n = 0;
        do begin
            @(posedge CLK);
            #1;
            n++;
        end while (CUR_POS != p && n < budget);
        check({name, "_reach_timeout"}, int'(CUR_POS), int'(p));
    endtask

    // Monitor: any change of A/B/position is an output event to score.
    initial begin
        logic [1:0]  prev_ab;
        logic [11:0] prev_pos;
        int          cyc, last_edge;
        rec_t        r;
        prev_ab   = 2'b00;
        prev_pos  = '0;
        cyc       = 0;
        last_edge = 0;
        forever begin
            @(posedge CLK);
            #1;
            cyc++;
            if (!ARSTN) begin
                prev_ab  = {A_OUT, B_OUT};
                prev_pos = CUR_POS;
                continue;
            end
            if ({A_OUT, B_OUT} != prev_ab || CUR_POS != prev_pos) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_edge_pos", int'(CUR_POS), int'(prev_pos));
                end else begin
                    r = exp_q.pop_front();
                    check("edge_pos", int'(CUR_POS), int'(r.pos));
                    check("edge_ab", int'({A_OUT, B_OUT}), int'(r.ab));
                    check("edge_z", int'(Z_OUT), int'(r.z));
                    check("edge_dir", int'(DIR_OUT), int'(r.dir));
                    if (!r.load)
                        check("edge_one_toggle", $countones({A_OUT, B_OUT} ^ prev_ab), 1);
                    if (r.gap != 0)
                        check("edge_spacing", cyc - last_edge, r.gap);
                    $display("edge pos=%03h ab=%b%b z=%b dir=%b gap=%0d", CUR_POS, A_OUT, B_OUT,
                             Z_OUT, DIR_OUT, cyc - last_edge);
                end
                last_edge = cyc;
            end
            prev_ab  = {A_OUT, B_OUT};
            prev_pos = CUR_POS;
        end
    end

    // Loopback detector: one count per A/B edge, A leading B counts up.
    always @(posedge CLK or negedge ARSTN) begin
        if (!ARSTN) begin
            det_ab  <= 2'b00;
            det_cnt <= '0;
        end else begin
            det_ab <= {A_OUT, B_OUT};
            if (((ab_index({A_OUT, B_OUT}) - ab_index(det_ab)) & 3) == 1)
                det_cnt <= det_cnt + 12'd1;
            else if (((ab_index({A_OUT, B_OUT}) - ab_index(det_ab)) & 3) == 3)
                det_cnt <= det_cnt - 12'd1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [11:0] cur, tgt;
        logic [11:0] loop_tgts[6];
        ARSTN = 1'b0; EN_IN = 1'b0; LOAD_IN = 1'b0; INIT_COUNT = '0;
        TARGET_IN = '0; STEP_DIV = 16'd4; Z_COUNT = 12'h800;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_a", int'(A_OUT), 0);
        check("rst_b", int'(B_OUT), 0);
        check("rst_z", int'(Z_OUT), 0);
        check("rst_pos", int'(CUR_POS), 0);
        check("rst_dir", int'(DIR_OUT), 0);
        check("rst_busy", int'(BUSY), 0);
        ARSTN = 1'b1;
        @(negedge CLK);

        // 1: count up to 5, spacing 4, one clock latency
        push_path(12'd0, 12'd5, 0, 4);
        TARGET_IN = 12'd5; EN_IN = 1'b1;
        @(posedge CLK); #1;
        check("t1_busy_on_request", int'(BUSY), 1);
        check("t1_pos_before_edge", int'(CUR_POS), 0);
        @(posedge CLK); #1;
        check("t1_first_edge", int'(CUR_POS), 1);
        wait_pos("t1", 12'd5, 100);
        repeat (2) @(posedge CLK);
        #1 check("t1_busy_in_wait", int'(BUSY), 1);
        @(posedge CLK);
        #1 check("t1_busy_after_wait", int'(BUSY), 0);
        check("t1_dir", int'(DIR_OUT), 1);
        check("t1_queue_drained", exp_q.size(), 0);

        // 2: load near wrap, Z at 0
        @(negedge CLK);
        Z_COUNT = 12'h000; INIT_COUNT = 12'hFFE; TARGET_IN = 12'h002; LOAD_IN = 1'b1;
        push_step(12'hFFE, exp_dir, 0, 1'b1);
        push_path(12'hFFE, 12'h002, 4, 4);
        @(negedge CLK);
        LOAD_IN = 1'b0;
        wait_idle("t2", 100);
        check("t2_pos", int'(CUR_POS), 2);

        // 3: reversal mid-motion
        Z_COUNT = 12'h800; INIT_COUNT = 12'd10; TARGET_IN = 12'd20; LOAD_IN = 1'b1;
        push_step(12'd10, exp_dir, 0, 1'b1);
        push_path(12'd10, 12'd13, 4, 4);
        @(negedge CLK);
        LOAD_IN = 1'b0;
        wait_pos("t3", 12'd13, 100);
        @(negedge CLK);
        TARGET_IN = 12'd7;
        push_path(12'd13, 12'd7, 4, 4);
        wait_idle("t3", 100);
        check("t3_pos", int'(CUR_POS), 7);
        check("t3_dir", int'(DIR_OUT), 0);

        // 4: spacing clamp and long spacing
        STEP_DIV = 16'd0; TARGET_IN = 12'd10;
        push_path(12'd7, 12'd10, 0, 2);
        wait_idle("t4_div0", 50);
        STEP_DIV = 16'd1; TARGET_IN = 12'd14;
        push_path(12'd10, 12'd14, 0, 2);
        wait_idle("t4_div1", 50);
        STEP_DIV = 16'd1000; TARGET_IN = 12'd16;
        push_path(12'd14, 12'd16, 0, 1000);
        wait_idle("t4_div1000", 3000);
        check("t4_pos", int'(CUR_POS), 16);

        // 5: enable drop and resume
        STEP_DIV = 16'd4; TARGET_IN = 12'd26;
        push_path(12'd16, 12'd18, 0, 4);
        wait_pos("t5", 12'd18, 100);
        @(negedge CLK);
        EN_IN = 1'b0;
        repeat (20) @(negedge CLK);
        check("t5_hold_pos", int'(CUR_POS), 18);
        check("t5_hold_busy", int'(BUSY), 0);
        check("t5_hold_queue", exp_q.size(), 0);
        EN_IN = 1'b1;
        push_path(12'd18, 12'd26, 0, 4);
        wait_idle("t5_resume", 100);
        check("t5_pos", int'(CUR_POS), 26);

        // 5b: asynchronous reset in WAIT, Z high at 28 beforehand
        Z_COUNT = 12'd28; TARGET_IN = 12'd30;
        push_path(12'd26, 12'd28, 0, 4);
        wait_pos("t5b", 12'd28, 100);
        #2 ARSTN = 1'b0;
        #1;
        check("t5b_a", int'(A_OUT), 0);
        check("t5b_b", int'(B_OUT), 0);
        check("t5b_z", int'(Z_OUT), 0);
        check("t5b_pos", int'(CUR_POS), 0);
        check("t5b_busy", int'(BUSY), 0);
        check("t5b_queue", exp_q.size(), 0);
        EN_IN = 1'b0; TARGET_IN = '0; exp_dir = 1'b0;
        repeat (2) @(negedge CLK);
        ARSTN = 1'b1;
        @(negedge CLK);

        // 6: loopback into detector, including wrap
        EN_IN = 1'b1; STEP_DIV = 16'd4; Z_COUNT = 12'h000;
        loop_tgts = '{12'hFFA, 12'h009, 12'hFF0, 12'h020, 12'h003, 12'h010};
        cur = '0;
        for (int i = 0; i < 10; i++) begin
            if (i >= 4 && i < 8) tgt = cur + 12'($urandom_range(0, 40)) - 12'd20;
            else if (i < 4) tgt = loop_tgts[i];
            else tgt = loop_tgts[i - 4];
            push_path(cur, tgt, 0, 4);
            TARGET_IN = tgt;
            wait_idle("t6", 400);
            check("t6_pos", int'(CUR_POS), int'(tgt));
            check("t6_detector", int'(det_cnt), int'(tgt));
            $display("loopback target=%03h pos=%03h det=%03h", tgt, CUR_POS, det_cnt);
            cur = tgt;
        end

        // half turn resolves upward
        STEP_DIV = 16'd2; Z_COUNT = 12'h801; INIT_COUNT = 12'h001; TARGET_IN = 12'h801;
        LOAD_IN = 1'b1;
        push_step(12'h001, exp_dir, 0, 1'b1);
        push_path(12'h001, 12'h801, 2, 2);
        @(negedge CLK);
        LOAD_IN = 1'b0;
        wait_idle("half_turn", 6000);
        check("half_turn_pos", int'(CUR_POS), 12'h801);
        check("half_turn_dir", int'(DIR_OUT), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
